pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall controller for multi-cycle EX ops and load-use bubbles
//
// Purpose:
//   Sequences multi-cycle EX-stage operations (madd/msub, div) through an
//   IDLE -> MULTI -> DONE state machine. Drives a per-stage hold vector so
//   upstream pipeline registers hold while the downstream register takes a
//   bubble. Also forwards ID load-use stall requests.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   stallreq_id  ID load-use hazard request
//   ex_start     EX holds the first cycle of a multi-cycle op
//   ex_kind      00 none, 01 madd/msub, 10 div, 11 reserved (treated as none)
//   stall[5:0]   hold per stage: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
//   ex_done      one-cycle pulse, EX result valid (state DONE)
//   busy         multi-cycle op in progress (state MULTI)
//   cnt          remaining-cycle counter (debug)
//
// Optional feature macro PIPE_CTRL_FLUSH_EN adds:
//   flush_req    exception/eret flush request from MEM, highest priority
//   flush        registered one-cycle pulse after flush_req is sampled

module pipe_ctrl #(
  parameter int MADD_CYCLES = 2,
  parameter int DIV_CYCLES  = 34,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_start,
  input  logic [1:0]       ex_kind,
`ifdef PIPE_CTRL_FLUSH_EN
  input  logic             flush_req,
  output logic             flush,
`endif
  output logic [5:0]       stall,
  output logic             ex_done,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MULTI = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Counter load values: the launching cycle itself counts as one stalled
  // cycle, so MULTI runs for N-1 cycles.
  localparam logic [CNT_W-1:0] MADD_LOAD = CNT_W'(MADD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_LU  = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  state_t state;

  logic start_valid;
  logic flush_now;

  assign start_valid = ex_start && ((ex_kind == 2'b01) || (ex_kind == 2'b10));

`ifdef PIPE_CTRL_FLUSH_EN
  assign flush_now = flush_req;
`else
  assign flush_now = 1'b0;
`endif

  // Same-cycle stall vector. The EX stall covers any load-use request.
  // Reset and flush both force the pipeline free so nothing latches stale holds.
  always_comb begin
    stall = STALL_NONE;
    if (rst || flush_now) begin
      stall = STALL_NONE;
    end else if (((state == IDLE) && start_valid) || (state == MULTI)) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_LU;
    end
  end

  // State machine with registered Moore outputs (busy/ex_done follow the
  // state being entered, so they line up exactly with the state register).
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ex_done <= 1'b0;
      busy    <= 1'b0;
`ifdef PIPE_CTRL_FLUSH_EN
      flush   <= 1'b0;
`endif
    end else if (flush_now) begin
      // Aborted op: drop straight to IDLE without a done pulse.
      state   <= IDLE;
      cnt     <= '0;
      ex_done <= 1'b0;
      busy    <= 1'b0;
`ifdef PIPE_CTRL_FLUSH_EN
      flush   <= 1'b1;
`endif
    end else begin
`ifdef PIPE_CTRL_FLUSH_EN
      flush   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          ex_done <= 1'b0;
          if (start_valid) begin
            state <= MULTI;
            busy  <= 1'b1;
            // ex_kind is only looked at here; later changes are irrelevant.
            cnt   <= (ex_kind == 2'b10) ? DIV_LOAD : MADD_LOAD;
          end else begin
            busy  <= 1'b0;
          end
        end
        MULTI: begin
          // ex_start is ignored: EX is still holding the launching op.
          if (cnt == CNT_ONE) begin
            state   <= DONE;
            busy    <= 1'b0;
            ex_done <= 1'b1;
          end else begin
            cnt     <= cnt - CNT_ONE;
          end
        end
        DONE: begin
          state   <= IDLE;
          cnt     <= '0;
          ex_done <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          ex_done <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic       stallreq_id;
  logic       ex_start;
  logic [1:0] ex_kind;
  logic [5:0] stall;
  logic       ex_done;
  logic       busy;
  logic [5:0] cnt;
`ifdef PIPE_CTRL_FLUSH_EN
  logic       flush_req;
  logic       flush;
`endif

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(
    .MADD_CYCLES(2),
    .DIV_CYCLES (34),
    .CNT_W      (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stallreq_id(stallreq_id),
    .ex_start   (ex_start),
    .ex_kind    (ex_kind),
`ifdef PIPE_CTRL_FLUSH_EN
    .flush_req  (flush_req),
    .flush      (flush),
`endif
    .stall      (stall),
    .ex_done    (ex_done),
    .busy       (busy),
    .cnt        (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to the next cycle: inputs are applied 1ns after the edge and
  // outputs are sampled 1ns later, well away from the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; ex_start = 1'b1; ex_kind = 2'b10;
`ifdef PIPE_CTRL_FLUSH_EN
    flush_req = 1'b0;
`endif
    @(posedge clk); #1;

    // Reset held two cycles with a div start present.
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("rst_stall%0d", i), 32'(stall), 32'h00);
      check($sformatf("rst_busy%0d", i), 32'(busy), 32'h0);
      check($sformatf("rst_cnt%0d", i), 32'(cnt), 32'h0);
      check($sformatf("rst_done%0d", i), 32'(ex_done), 32'h0);
      next_cycle();
    end
    rst = 1'b0; ex_start = 1'b0; ex_kind = 2'b00;
    settle();
    check("idle_stall", 32'(stall), 32'h00);
    check("idle_busy", 32'(busy), 32'h0);

    // Load-use bubble in IDLE.
    stallreq_id = 1'b1;
    settle();
    check("lu_stall", 32'(stall), 32'h07);
    // Reserved / none kinds never launch.
    ex_start = 1'b1; ex_kind = 2'b11;
    settle();
    check("kind11_stall", 32'(stall), 32'h07);
    next_cycle();
    stallreq_id = 1'b0;
    ex_kind = 2'b00;
    settle();
    check("kind11_busy", 32'(busy), 32'h0);
    check("kind00_stall", 32'(stall), 32'h00);
    next_cycle();
    ex_start = 1'b0;

    // Div op with ignored starts at T+5 and T+34, load-use at T+10,
    // and a madd launched at T+35.
    for (int i = 0; i <= 35; i++) begin
      ex_start    = (i == 0) || (i == 5) || (i == 34) || (i == 35);
      ex_kind     = (i == 0) ? 2'b10 : 2'b01;
      stallreq_id = (i == 10) || (i == 34 ? 1'b0 : 1'b0);
      settle();
      check($sformatf("div_stall%0d", i), 32'(stall),
            (i <= 33 || i == 35) ? 32'h0f : 32'h00);
      check($sformatf("div_busy%0d", i), 32'(busy), (i >= 1 && i <= 33) ? 32'h1 : 32'h0);
      check($sformatf("div_done%0d", i), 32'(ex_done), (i == 34) ? 32'h1 : 32'h0);
      if (i <= 33)
        check($sformatf("div_cnt%0d", i), 32'(cnt), (i == 0) ? 32'd0 : 32'(34 - i));
      next_cycle();
    end
    ex_start = 1'b0; ex_kind = 2'b00; stallreq_id = 1'b0;

    // Madd launched above (j=0 was i=35); j=1..3 here.
    for (int j = 1; j <= 3; j++) begin
      if (j == 1) stallreq_id = 1'b1;
      else stallreq_id = 1'b0;
      settle();
      check($sformatf("madd_stall%0d", j), 32'(stall), (j == 1) ? 32'h0f : 32'h00);
      check($sformatf("madd_busy%0d", j), 32'(busy), (j == 1) ? 32'h1 : 32'h0);
      check($sformatf("madd_done%0d", j), 32'(ex_done), (j == 2) ? 32'h1 : 32'h0);
      if (j != 2)
        check($sformatf("madd_cnt%0d", j), 32'(cnt), (j == 1) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // Reset in the middle of a div: aborted, no done.
    for (int i = 0; i <= 40; i++) begin
      ex_start = (i == 0);
      ex_kind  = 2'b10;
      rst      = (i == 3);
      settle();
      if (i == 3) check("mrst_stall_now", 32'(stall), 32'h00);
      if (i == 4) begin
        check("mrst_stall", 32'(stall), 32'h00);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_cnt", 32'(cnt), 32'h0);
      end
      if (i >= 4) check($sformatf("mrst_done%0d", i), 32'(ex_done), 32'h0);
      next_cycle();
    end
    rst = 1'b0; ex_start = 1'b0;

`ifdef PIPE_CTRL_FLUSH_EN
    // Flush at T+10 of a div.
    for (int i = 0; i <= 40; i++) begin
      ex_start  = (i == 0);
      ex_kind   = 2'b10;
      flush_req = (i == 10);
      settle();
      if (i == 10) check("fl_stall_now", 32'(stall), 32'h00);
      if (i == 11) begin
        check("fl_busy", 32'(busy), 32'h0);
        check("fl_stall", 32'(stall), 32'h00);
        check("fl_cnt", 32'(cnt), 32'h0);
      end
      check($sformatf("fl_flush%0d", i), 32'(flush), (i == 11) ? 32'h1 : 32'h0);
      check($sformatf("fl_done%0d", i), 32'(ex_done), 32'h0);
      next_cycle();
    end
    flush_req = 1'b0; ex_start = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
